// File: rtl/uart_rx_fifo.sv
// Receive-side word buffer between the UART receiver and its consumer.
// First-word-fall-through read port, explicit occupancy counter, sticky overflow flag.
module uart_rx_fifo #(
    parameter int WORD_WIDTH        = 8,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORD_WIDTH-1:0]      din,
    input  logic                       we,
    output logic                       full,
    output logic [WORD_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_acc_s, rd_acc_s;

    // Flags decode only the registered count, so we never reaches full combinationally.
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == {CW{1'b0}});
        almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
        dout_valid  = !empty;
        count       = count_q;
        overflow    = overflow_q;
        if (empty) begin
            dout = {WORD_WIDTH{1'b0}};
        end else begin
            dout = mem_q[rd_ptr_q];
        end
    end

    // Next-state for pointers, occupancy and overflow.
    always_comb begin
        wr_acc_s   = we && !full;
        rd_acc_s   = dout_ready && !empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A dropped write wins over a simultaneous clear.
        if (we && full) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: vector table plus hand-written
// sequences for fill/overflow, streaming wrap-around and asynchronous reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       we;
    logic       full;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.WORD_WIDTH(8), .DEPTH(16), .ALMOST_FULL_LEVEL(14)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .we(we), .full(full),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .empty(empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic [7:0] e_dout;
        logic       e_valid;
        logic       e_empty;
        logic       e_full;
        logic       e_af;
        logic       e_ovf;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] pack(logic [7:0] d, logic v, logic e, logic f,
                                         logic af, logic o, logic [4:0] c);
        return {14'd0, d, v, e, f, af, o, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] d, input logic v, input logic e,
                           input logic f, input logic af, input logic o, input logic [4:0] c);
        chk(name, pack(dout, dout_valid, empty, full, almost_full, overflow, count),
            pack(d, v, e, f, af, o, c));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        we = w; din = d; dout_ready = r; overflow_clr = c;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; din = 8'h00; dout_ready = 1'b0; overflow_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] head;
        rst_n = 1'b0; we = 1'b0; din = 8'h00; dout_ready = 1'b0; overflow_clr = 1'b0;

        // order: we din rdy clr | dout valid empty full af ovf count
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};
        vecs[5] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};

        #1;
        chk_all("reset_state", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, empty read, no-bypass write+ready, mixed read/write.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].we, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_valid, vecs[i].e_empty,
                    vecs[i].e_full, vecs[i].e_af, vecs[i].e_ovf, vecs[i].e_cnt);
        end

        // Fill to full, checking almost_full / full boundaries.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill_af%0d", i), 32'(almost_full), 32'((i + 1) >= 14));
            chk($sformatf("fill_full%0d", i), 32'(full), 32'((i + 1) == 16));
            chk($sformatf("fill_head%0d", i), 32'(dout), 32'h00);
        end

        // Dropped write while full; the same-cycle read does not make room.
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk_all("drop_read", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd15);
        step(1'b1, 8'h10, 1'b0, 1'b0);
        chk_all("refill", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd16);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk_all("drop_vs_clr", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_all("clr_alone", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d", i), 32'(dout), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_all("drained", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

        // Streaming with 3 words resident; 43 writes wrap the pointers twice.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        head = 8'h00;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("stream_head%0d", i), 32'(dout), 32'(head));
            step(1'b1, 8'(i + 3), 1'b1, 1'b0);
            head = head + 8'h01;
            chk($sformatf("stream_count%0d", i), 32'(count), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stream_tail%0d", i), 32'(dout), 32'(40 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("stream_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        chk_all("pre_reset", 8'h70, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7);
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h6B, 1'b0, 1'b0);
        chk_all("post_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_all("post_reset_rd", 8'h6B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
